// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit adder resolving CHUNK bits per registered stage, valid/ready on both sides.
// Define ADDER_OVF_EN to add the signed-overflow output ovf_o, aligned with sum_o.
module pipelined_carry_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic                         stall;
  logic                         unused_op_bits;

  // The whole pipe freezes while the head result waits for the consumer.
  assign stall      = valid_q[LAST] && !out_ready_i;
  assign in_ready_o = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int CW = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;

    logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic             c_in, v_in;
    logic [CW:0]      part;

    if (k == 0) begin : g_head
      assign a_in = a_i;
      assign b_in = b_i;
      assign s_in = '0;
      assign c_in = cin_i;
      assign v_in = in_valid_i;
    end else begin : g_tail
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = sum_q[k-1];
      assign c_in = carry_q[k-1];
      assign v_in = valid_q[k-1];
    end

    assign part = {1'b0, a_in[LO +: CW]} + {1'b0, b_in[LO +: CW]} + {{CW{1'b0}}, c_in};

    always_comb begin
      s_nxt            = s_in;
      s_nxt[LO +: CW]  = part[CW-1:0];
    end

    assign valid_d[k] = v_in;
    assign carry_d[k] = part[CW];
    assign sum_d[k]   = s_nxt;
    assign a_d[k]     = a_in;
    assign b_d[k]     = b_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign out_valid_o = valid_q[LAST];
  assign sum_o       = sum_q[LAST];
  assign cout_o      = carry_q[LAST];

  // Already-consumed low operand chunks ride along but are never needed again.
  assign unused_op_bits = ^{a_q, b_q};

`ifdef ADDER_OVF_EN
  assign ovf_o = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                 (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=32, CHUNK=8): vector table plus scoreboarded streams.
module tb_pipelined_carry_adder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_i, in_ready_o;
  logic [W-1:0] a_i, b_i;
  logic         cin_i;
  logic         out_valid_o, out_ready_i;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;

  pipelined_carry_adder #(.WIDTH(W), .CHUNK(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o)
`ifdef ADDER_OVF_EN
    ,
    .ovf_o       (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t       e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    in_valid_i = v;
    a_i        = a;
    b_i        = b;
    cin_i      = c;
    cur_exp    = model(a, b, c);
  endtask

  // Evaluate handshakes mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    #2;
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("sum", 64'(sum_o), 64'(e.sum));
        check("cout", 64'(cout_o), 64'(e.cout));
`ifdef ADDER_OVF_EN
        check("ovf", 64'(ovf_o), 64'(e.ovf));
`endif
      end
    end
    if (in_valid_i && in_ready_o) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    check(name, 64'(sb.size()), 64'd0);
    check({name, "_idle"}, 64'(out_valid_o), 64'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int   cnt;
    logic [W-1:0] held_sum;
    logic         held_cout;

    vecs[0] = '{32'h0000_0003, 32'h0000_0001, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[8] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    rst         = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_sum", 64'(sum_o), 64'd0);
    check("rst_cout", 64'(cout_o), 64'd0);
`ifdef ADDER_OVF_EN
    check("rst_ovf", 64'(ovf_o), 64'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Single transaction latency.
    drive(1'b1, 32'h3, 32'h1, 1'b0);
    cur_exp = '{32'h4, 1'b0, 1'b0};
    tick();
    drive(1'b0, '0, '0, 1'b0);
    cnt = 1;
    while (!out_valid_o && cnt < 20) begin
      tick();
      cnt++;
    end
    check("latency", 64'(cnt), 64'd4);
    drain("lat_drain");

    // Vector table, back to back.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      cur_exp = '{vecs[i].sum, vecs[i].cout, vecs[i].ovf};
      tick();
    end
    drain("table_drain");

    // 100 random operands, full rate; drain must take exactly STAGES cycles.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      tick();
    end
    in_valid_i = 1'b0;
    cnt = 0;
    while (sb.size() > 0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("stream_drain_cycles", 64'(cnt), 64'd4);
    check("stream_idle", 64'(out_valid_o), 64'd0);

    // Backpressure with a full pipe.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      tick();
    end
    check("bp_full", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b0;
    drive(1'b1, $urandom(), $urandom(), 1'b0);
    held_sum  = sum_o;
    held_cout = cout_o;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 64'(in_ready_o), 64'd0);
      tick();
      check("bp_valid_hold", 64'(out_valid_o), 64'd1);
      check("bp_sum_hold", 64'(sum_o), 64'(held_sum));
      check("bp_cout_hold", 64'(cout_o), 64'(held_cout));
    end
    drain("bp_drain");

    // Random bubbles and random backpressure.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom_range(0, 1)));
      out_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("bubble_drain");

    // Reset with results in flight, one already presented.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom(), $urandom(), 1'b1);
      tick();
    end
    in_valid_i = 1'b0;
    check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid_o), 64'd0);
    check("mid_rst_sum", 64'(sum_o), 64'd0);
    check("mid_rst_cout", 64'(cout_o), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_o) cnt++;
      tick();
    end
    check("post_rst_stale", 64'(cnt), 64'd0);
    check("post_rst_in_ready", 64'(in_ready_o), 64'd1);

    // Pipe still works after the mid-flight reset.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
    cur_exp = '{32'h0, 1'b1, 1'b0};
    tick();
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
